mac_dot_sequencer: RTL and testbench

Sequencer that drives one shared `multiply_accumulate` instance (unsigned 32×32 product plus a 64-bit addend, giving a 64-bit result) to compute a length-N dot product with a bias. Element pairs are accepted over a valid/ready stream, one pair per cycle. The accumulated result is held on a valid/ready output until the consumer takes it. The block sits between an operand-fetch stage and a result consumer, and is the only user of its MAC instance.

---
 rtl/mac_dot_sequencer_if.sv | 31 +++
 rtl/mac_dot_sequencer.sv | 124 ++++++++++++
 tb/tb_mac_dot_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_sequencer_if.sv
// mac_dot_sequencer_if: operand-pair input stream and result output stream.
// The sequencer takes the slave side; the producer/consumer take master.
interface mac_dot_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: length-N dot product plus bias over one shared MAC.
// Optional macro MAC_DOT_SAT_EN saturates the accumulator on overflow.
module multiply_accumulate (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] c,
    output logic [63:0] y
);
    assign y = (64'(a) * 64'(b)) + c;
endmodule

module mac_dot_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    input  logic [63:0]      bias,
    output logic             busy,
    mac_dot_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [63:0]      acc_q;
    logic [63:0]      acc_d;
    logic [LEN_W-1:0] remaining_q;
    logic [63:0]      mac_out;
    logic             fire;
    logic             launch;
    logic             last;

    multiply_accumulate u_mac (
        .a (bus.in_a),
        .b (bus.in_b),
        .c (acc_q),
        .y (mac_out)
    );

    assign fire   = bus.in_valid && bus.in_ready;
    assign launch = (state_q == IDLE) && start && !abort;
    assign last   = remaining_q == LEN_W'(1);

`ifdef MAC_DOT_SAT_EN
    // A wrapped sum is always smaller than the addend it started from.
    assign acc_d = (mac_out < acc_q) ? 64'hFFFF_FFFF_FFFF_FFFF : mac_out;
`else
    assign acc_d = mac_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fire && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        busy          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: ;
            RUN: begin
                busy         = 1'b1;
                bus.in_ready = 1'b1;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            acc_q       <= '0;
            remaining_q <= '0;
        end else if (launch) begin
            acc_q       <= bias;
            remaining_q <= len;
        end else if (fire) begin
            acc_q       <= acc_d;
            remaining_q <= remaining_q - LEN_W'(1);
        end
    end

    assign bus.out_data = acc_q;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: directed checks of the dot-product sequencer.
// Expected results are hand-computed per scenario.
module tb_mac_dot_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  len;
    logic [63:0] bias;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    mac_dot_sequencer_if bus ();

    mac_dot_sequencer #(.LEN_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .len   (len),
        .bias  (bias),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run1(input string tag, input logic [63:0] b0,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
        start = 1'b1;
        len = 8'd1;
        bias = b0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.out_ready = 1'b0;
        step();
        start = 1'b0;
        chk({tag, "_ready"}, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_data"}, bus.out_data, exp);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        len = '0;
        bias = '0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);

        // basic: 3 + 1*2 + 3*5 + 2*3 = 26
        start = 1'b1;
        len = 8'd3;
        bias = 64'd3;
        bus.in_valid = 1'b1;
        bus.in_a = 32'd1;
        bus.in_b = 32'd2;
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        chk("basic_busy", busy, 1);
        chk("basic_in_ready", bus.in_ready, 1);
        step();
        chk("basic_ov_t1", bus.out_valid, 0);
        bus.in_a = 32'd3;
        bus.in_b = 32'd5;
        step();
        chk("basic_ov_t2", bus.out_valid, 0);
        bus.in_a = 32'd2;
        bus.in_b = 32'd3;
        step();
        bus.in_valid = 1'b0;
        chk("basic_ov_t3", bus.out_valid, 1);
        chk("basic_data", bus.out_data, 64'h1A);
        chk("basic_in_ready_done", bus.in_ready, 0);
        step();
        chk("basic_busy_after", busy, 0);
        chk("basic_ov_after", bus.out_valid, 0);

        // empty job: pair on the bus must not be consumed
        start = 1'b1;
        len = 8'd0;
        bias = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.in_valid = 1'b1;
        bus.in_a = 32'd9;
        bus.in_b = 32'd9;
        bus.out_ready = 1'b0;
        step();
        start = 1'b0;
        chk("empty_valid", bus.out_valid, 1);
        chk("empty_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("empty_in_ready", bus.in_ready, 0);
        step();
        chk("empty_held", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("empty_idle", busy, 0);

        run1("wide", 64'd0, 32'hFFFF_FFFE, 32'd2, 64'h1_FFFF_FFFC);
`ifdef MAC_DOT_SAT_EN
        run1("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 32'd1,
             64'hFFFF_FFFF_FFFF_FFFF);
`else
        run1("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 32'd1, 64'h0);
`endif

        // backpressure: 0 + 4*4 + 1*1 = 17
        start = 1'b1;
        len = 8'd2;
        bias = 64'd0;
        bus.in_valid = 1'b1;
        bus.in_a = 32'd4;
        bus.in_b = 32'd4;
        bus.out_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_gap_ready", bus.in_ready, 1);
            chk("bp_gap_ov", bus.out_valid, 0);
        end
        bus.in_valid = 1'b1;
        bus.in_a = 32'd1;
        bus.in_b = 32'd1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len = 8'd3;
            bias = 64'd5;
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_data", bus.out_data, 64'h11);
            step();
        end
        start = 1'b0;
        chk("bp_final_data", bus.out_data, 64'h11);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp_idle", busy, 0);
        step();
        chk("bp_no_queue", busy, 0);

        // abort after first pair
        start = 1'b1;
        len = 8'd3;
        bias = 64'd7;
        bus.in_valid = 1'b1;
        bus.in_a = 32'd2;
        bus.in_b = 32'd2;
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_acc", bus.out_data, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_ov", bus.out_valid, 0);
        end
        bus.in_valid = 1'b0;
        run1("restart", 64'd0, 32'd4, 32'd4, 64'h10);

        // abort beats start
        start = 1'b1;
        abort = 1'b1;
        len = 8'd1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", busy, 0);

        // reset while a result is pending
        start = 1'b1;
        len = 8'd0;
        bias = 64'h1234;
        bus.out_ready = 1'b0;
        step();
        start = 1'b0;
        chk("rdone_valid", bus.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rdone_ov", bus.out_valid, 0);
        chk("rdone_busy", busy, 0);
        chk("rdone_in_ready", bus.in_ready, 0);
        chk("rdone_data", bus.out_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
